exe_stage: RTL

- Execute stage; sits directly downstream of the register-fetch stage.
- Consumes the decoded micro-op (opcode_help, Imm, Wr_id, Fmask, EOI, Rd_data0/1, seqNPC) plus the RF bubble indication.
- Computes the ALU result and Z80-style flags, and forms load/store addresses.
- Resolves branches and drives the front end (flush1, PCupdate, EXE_targetPC). Results are registered into the EXE/MEM latch.

---
 rtl/exe_pkg.sv | 64 ++++++
 rtl/exe_stage_if.sv | 43 ++++
 rtl/exe_alu.sv | 132 +++++++++++++
 rtl/exe_stage.sv | 126 ++++++++++++
 4 files changed

// File: rtl/exe_pkg.sv
// Shared definitions for the execute stage: opcode map, Z80 flag positions,
// branch condition codes and the EXE/MEM latch layout.
package exe_pkg;

    typedef logic [5:0] opcode_t;

    localparam opcode_t OP_NOP   = 6'd0;
    localparam opcode_t OP_ADD   = 6'd1;
    localparam opcode_t OP_ADC   = 6'd2;
    localparam opcode_t OP_SUB   = 6'd3;
    localparam opcode_t OP_SBC   = 6'd4;
    localparam opcode_t OP_AND   = 6'd5;
    localparam opcode_t OP_OR    = 6'd6;
    localparam opcode_t OP_XOR   = 6'd7;
    localparam opcode_t OP_CP    = 6'd8;
    localparam opcode_t OP_INC   = 6'd9;
    localparam opcode_t OP_DEC   = 6'd10;
    localparam opcode_t OP_RLC   = 6'd11;
    localparam opcode_t OP_RRC   = 6'd12;
    localparam opcode_t OP_RL    = 6'd13;
    localparam opcode_t OP_RR    = 6'd14;
    localparam opcode_t OP_SLA   = 6'd15;
    localparam opcode_t OP_SRA   = 6'd16;
    localparam opcode_t OP_SRL   = 6'd17;
    localparam opcode_t OP_ADD16 = 6'd18;
    localparam opcode_t OP_INC16 = 6'd19;
    localparam opcode_t OP_DEC16 = 6'd20;
    localparam opcode_t OP_MOV   = 6'd21;
    localparam opcode_t OP_LDI   = 6'd22;
    localparam opcode_t OP_LD    = 6'd23;
    localparam opcode_t OP_ST    = 6'd24;
    localparam opcode_t OP_JP    = 6'd25;
    localparam opcode_t OP_JR    = 6'd26;
    localparam opcode_t OP_JPR   = 6'd27;
    localparam opcode_t OP_JPC   = 6'd28;
    localparam opcode_t OP_JRC   = 6'd29;

    localparam int unsigned FLAG_S  = 7;
    localparam int unsigned FLAG_Z  = 6;
    localparam int unsigned FLAG_H  = 4;
    localparam int unsigned FLAG_PV = 2;
    localparam int unsigned FLAG_N  = 1;
    localparam int unsigned FLAG_C  = 0;

    typedef enum logic [2:0] {
        CC_NZ, CC_Z, CC_NC, CC_C, CC_PO, CC_PE, CC_P, CC_M
    } cc_e;

    typedef struct packed {
        opcode_t     opcode;
        logic [4:0]  wr_id;
        logic [7:0]  fmask;
        logic [15:0] result;
        logic [7:0]  flags;
        logic [15:0] st_data;
        logic        eoi;
    } exe_latch_t;

    // Z80 PV in parity mode: 1 for an even number of set bits.
    function automatic logic parity8(input logic [7:0] v);
        return ~^v;
    endfunction

endpackage

// File: rtl/exe_stage_if.sv
// RF -> EXE micro-op bus plus EXE outputs (front-end redirect and EXE/MEM latch).
interface exe_stage_if;
    import exe_pkg::*;

    opcode_t     opcode_help;
    logic [15:0] Imm;
    logic [4:0]  Wr_id;
    logic [7:0]  Fmask;
    logic        EOI;
    logic [15:0] Rd_data0;
    logic [4:0]  Rd0_id;
    logic [15:0] Rd_data1;
    logic [4:0]  Rd1_id;
    logic [15:0] seqNPC;
    logic        bubble;
    logic        mem_pipe_stall;

    logic        flush1;
    logic        PCupdate;
    logic [15:0] EXE_targetPC;
    opcode_t     EXE_opcode;
    logic [4:0]  EXE_Wr_id;
    logic [7:0]  EXE_Fmask;
    logic [15:0] EXE_Result;
    logic [7:0]  EXE_Flags;
    logic [15:0] EXE_StData;
    logic        EXE_EOI;

    modport master (
        output opcode_help, Imm, Wr_id, Fmask, EOI, Rd_data0, Rd0_id,
               Rd_data1, Rd1_id, seqNPC, bubble, mem_pipe_stall,
        input  flush1, PCupdate, EXE_targetPC, EXE_opcode, EXE_Wr_id,
               EXE_Fmask, EXE_Result, EXE_Flags, EXE_StData, EXE_EOI
    );

    modport slave (
        input  opcode_help, Imm, Wr_id, Fmask, EOI, Rd_data0, Rd0_id,
               Rd_data1, Rd1_id, seqNPC, bubble, mem_pipe_stall,
        output flush1, PCupdate, EXE_targetPC, EXE_opcode, EXE_Wr_id,
               EXE_Fmask, EXE_Result, EXE_Flags, EXE_StData, EXE_EOI
    );

endinterface

// File: rtl/exe_alu.sv
// Combinational ALU: 8-bit Z80-style arithmetic/logic/shift ops with flags,
// 16-bit add/inc/dec, moves and address generation.
module exe_alu
    import exe_pkg::*;
(
    input  opcode_t     op_i,
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        cin_i,
    output logic [15:0] result_o,
    output logic [7:0]  flags_o
);

    logic [7:0]  a8;
    logic [7:0]  opb;
    logic [7:0]  r8;
    logic [8:0]  sum9;
    logic [16:0] sum17;
    logic        h4;
    logic        h12;
    logic        is_sub;
    logic        ci;
    logic        keep_c;
    logic        fl8;
    logic        par;
    logic        c;
    logic        h;
    logic        pv;
    logic        n;

    assign a8 = a_i[7:0];

    // INC/DEC share the adder with B forced to 1 and carry left as it was.
    always_comb begin
        is_sub = 1'b0;
        opb    = b_i[7:0];
        ci     = 1'b0;
        keep_c = 1'b0;
        case (op_i)
            OP_ADC:        ci = cin_i;
            OP_SUB, OP_CP: is_sub = 1'b1;
            OP_SBC: begin
                is_sub = 1'b1;
                ci     = cin_i;
            end
            OP_INC: begin
                opb    = 8'h01;
                keep_c = 1'b1;
            end
            OP_DEC: begin
                is_sub = 1'b1;
                opb    = 8'h01;
                keep_c = 1'b1;
            end
            default: ;
        endcase
    end

    assign sum9  = is_sub ? ({1'b0, a8} - {1'b0, opb} - {8'h00, ci})
                          : ({1'b0, a8} + {1'b0, opb} + {8'h00, ci});
    assign h4    = a8[4] ^ opb[4] ^ sum9[4];
    assign sum17 = {1'b0, a_i} + {1'b0, b_i};
    assign h12   = a_i[12] ^ b_i[12] ^ sum17[12];

    always_comb begin
        r8       = '0;
        fl8      = 1'b0;
        par      = 1'b0;
        c        = 1'b0;
        h        = 1'b0;
        pv       = 1'b0;
        n        = 1'b0;
        result_o = '0;
        flags_o  = '0;
        case (op_i)
            OP_ADD, OP_ADC, OP_INC: begin
                fl8 = 1'b1;
                r8  = sum9[7:0];
                c   = keep_c ? cin_i : sum9[8];
                h   = h4;
                pv  = (a8[7] == opb[7]) && (r8[7] != a8[7]);
            end
            OP_SUB, OP_SBC, OP_CP, OP_DEC: begin
                fl8 = 1'b1;
                r8  = sum9[7:0];
                c   = keep_c ? cin_i : sum9[8];
                h   = h4;
                pv  = (a8[7] != opb[7]) && (r8[7] != a8[7]);
                n   = 1'b1;
            end
            OP_AND: begin
                fl8 = 1'b1; par = 1'b1; h = 1'b1;
                r8  = a8 & b_i[7:0];
            end
            OP_OR: begin
                fl8 = 1'b1; par = 1'b1;
                r8  = a8 | b_i[7:0];
            end
            OP_XOR: begin
                fl8 = 1'b1; par = 1'b1;
                r8  = a8 ^ b_i[7:0];
            end
            OP_RLC: begin fl8 = 1'b1; par = 1'b1; r8 = {a8[6:0], a8[7]}; c = a8[7]; end
            OP_RRC: begin fl8 = 1'b1; par = 1'b1; r8 = {a8[0], a8[7:1]};  c = a8[0]; end
            OP_RL:  begin fl8 = 1'b1; par = 1'b1; r8 = {a8[6:0], cin_i};  c = a8[7]; end
            OP_RR:  begin fl8 = 1'b1; par = 1'b1; r8 = {cin_i, a8[7:1]};  c = a8[0]; end
            OP_SLA: begin fl8 = 1'b1; par = 1'b1; r8 = {a8[6:0], 1'b0};   c = a8[7]; end
            OP_SRA: begin fl8 = 1'b1; par = 1'b1; r8 = {a8[7], a8[7:1]};  c = a8[0]; end
            OP_SRL: begin fl8 = 1'b1; par = 1'b1; r8 = {1'b0, a8[7:1]};   c = a8[0]; end
            OP_ADD16: begin
                result_o         = sum17[15:0];
                flags_o[FLAG_C]  = sum17[16];
                flags_o[FLAG_H]  = h12;
            end
            OP_INC16:       result_o = a_i + 16'd1;
            OP_DEC16:       result_o = a_i - 16'd1;
            OP_MOV, OP_LDI: result_o = b_i;
            OP_LD, OP_ST:   result_o = sum17[15:0];
            default: ;
        endcase
        if (fl8) begin
            result_o         = {8'h00, (op_i == OP_CP) ? a8 : r8};
            flags_o[FLAG_S]  = r8[7];
            flags_o[FLAG_Z]  = (r8 == 8'h00);
            flags_o[FLAG_H]  = h;
            flags_o[FLAG_PV] = par ? parity8(r8) : pv;
            flags_o[FLAG_N]  = n;
            flags_o[FLAG_C]  = c;
        end
    end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: ALU, branch resolution with one-shot front-end redirect,
// and the EXE/MEM pipeline latch.
module exe_stage
    import exe_pkg::*;
(
    input logic        CLK,
    input logic        RST,
    exe_stage_if.slave bus
);

    exe_latch_t  latch_d;
    exe_latch_t  latch_q;
    logic        redirect_done_d;
    logic        redirect_done_q;
    logic        valid;
    logic        is_branch;
    logic        need_cc;
    logic        cond_ok;
    logic        taken;
    logic        pulse;
    logic [15:0] br_target;
    logic [15:0] jr_target;
    logic [15:0] alu_b;
    logic [15:0] alu_result;
    logic [7:0]  alu_flags;
    logic        unused_ids;

    assign unused_ids = ^{bus.Rd0_id, bus.Rd1_id};

    assign valid = !bus.bubble && (bus.opcode_help != OP_NOP);

    assign alu_b = (bus.opcode_help == OP_LD || bus.opcode_help == OP_ST ||
                    bus.opcode_help == OP_LDI) ? bus.Imm : bus.Rd_data1;

    exe_alu u_alu (
        .op_i     (bus.opcode_help),
        .a_i      (bus.Rd_data0),
        .b_i      (alu_b),
        .cin_i    (bus.Rd_data1[8]),
        .result_o (alu_result),
        .flags_o  (alu_flags)
    );

    assign jr_target = bus.seqNPC + {{8{bus.Imm[7]}}, bus.Imm[7:0]};

    // For conditional branches the RF places the current F in Rd_data0[7:0].
    always_comb begin
        cond_ok = 1'b0;
        case (cc_e'(bus.Imm[10:8]))
            CC_NZ: cond_ok = !bus.Rd_data0[FLAG_Z];
            CC_Z:  cond_ok =  bus.Rd_data0[FLAG_Z];
            CC_NC: cond_ok = !bus.Rd_data0[FLAG_C];
            CC_C:  cond_ok =  bus.Rd_data0[FLAG_C];
            CC_PO: cond_ok = !bus.Rd_data0[FLAG_PV];
            CC_PE: cond_ok =  bus.Rd_data0[FLAG_PV];
            CC_P:  cond_ok = !bus.Rd_data0[FLAG_S];
            CC_M:  cond_ok =  bus.Rd_data0[FLAG_S];
            default: cond_ok = 1'b0;
        endcase
    end

    always_comb begin
        is_branch = 1'b0;
        need_cc   = 1'b0;
        br_target = '0;
        case (bus.opcode_help)
            OP_JP:  begin is_branch = 1'b1; br_target = bus.Imm; end
            OP_JR:  begin is_branch = 1'b1; br_target = jr_target; end
            OP_JPR: begin is_branch = 1'b1; br_target = bus.Rd_data0; end
            OP_JPC: begin is_branch = 1'b1; need_cc = 1'b1; br_target = bus.Imm; end
            OP_JRC: begin is_branch = 1'b1; need_cc = 1'b1; br_target = jr_target; end
            default: ;
        endcase
    end

    assign taken = !RST && valid && is_branch && (!need_cc || cond_ok);
    assign pulse = taken && !redirect_done_q;

    assign bus.flush1       = pulse;
    assign bus.PCupdate     = pulse;
    assign bus.EXE_targetPC = taken ? br_target : 16'h0000;

    always_comb begin
        latch_d = '0;
        if (valid) begin
            latch_d.opcode  = bus.opcode_help;
            latch_d.wr_id   = bus.Wr_id;
            latch_d.fmask   = bus.Fmask;
            latch_d.result  = alu_result;
            latch_d.flags   = alu_flags;
            latch_d.st_data = bus.Rd_data1;
            latch_d.eoi     = bus.EOI;
        end
    end

    // A redirect issued during a MEM stall is remembered until the latch advances.
    always_comb begin
        redirect_done_d = redirect_done_q;
        if (!bus.mem_pipe_stall) begin
            redirect_done_d = 1'b0;
        end else if (pulse) begin
            redirect_done_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            latch_q         <= '0;
            redirect_done_q <= 1'b0;
        end else begin
            redirect_done_q <= redirect_done_d;
            if (!bus.mem_pipe_stall) begin
                latch_q <= latch_d;
            end
        end
    end

    assign bus.EXE_opcode = latch_q.opcode;
    assign bus.EXE_Wr_id  = latch_q.wr_id;
    assign bus.EXE_Fmask  = latch_q.fmask;
    assign bus.EXE_Result = latch_q.result;
    assign bus.EXE_Flags  = latch_q.flags;
    assign bus.EXE_StData = latch_q.st_data;
    assign bus.EXE_EOI    = latch_q.eoi;

endmodule
